// File: rtl/laplace_lut_uart_tx.sv
// laplace_lut_uart_tx: LUT character FIFO + 8N1 serialiser (8E1 when LUT_UART_PARITY_EN is defined)
module laplace_lut_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       char_last,
  output logic       char_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [4:0] fifo_level
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef LUT_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [4:0]    r_level;
  logic [2:0]    r_state, w_next, r_bit;
  logic [7:0]    r_baud, r_shift;
  logic          r_last, r_done;
  logic          w_tick, w_empty, w_push, w_pop;
`ifdef LUT_UART_PARITY_EN
  logic          r_par;
`endif
  assign w_empty    = r_level == 5'd0;
  assign char_ready = r_level != 5'(FIFO_DEPTH);
  assign w_push     = char_valid && char_ready;
  assign w_tick     = r_baud == 8'(CLK_DIV - 1);
  assign w_pop      = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_tick));
  assign fifo_level = r_level;
  assign busy       = r_state != S_IDLE || !w_empty;
  assign done       = r_done;
  // next state: each non-idle state lasts whole baud periods, STOP chains straight into START when data waits
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_empty ? S_IDLE : S_START;
      S_START:  w_next = w_tick ? S_DATA : S_START;
`ifdef LUT_UART_PARITY_EN
      S_DATA:   w_next = (w_tick && r_bit == 3'd7) ? S_PARITY : S_DATA;
      S_PARITY: w_next = w_tick ? S_STOP : S_PARITY;
`else
      S_DATA:   w_next = (w_tick && r_bit == 3'd7) ? S_STOP : S_DATA;
`endif
      S_STOP:   w_next = !w_tick ? S_STOP : (w_empty ? S_IDLE : S_START);
      default:  w_next = S_IDLE;
    endcase
  end
  // line level per state; idle and stop hold the line high
  always_comb begin
`ifdef LUT_UART_PARITY_EN
    tx = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_shift[0] : r_state == S_PARITY ? r_par : 1'b1;
`else
    tx = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_shift[0] : 1'b1;
`endif
  end
  // FIFO storage is never reset; validity is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {char_last, char_in};
  end
  // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level <= r_level + 5'(w_push) - 5'(w_pop);
    end
  end
  // serialiser: state, baud counter restarting on every bit boundary, shift register and end-of-message pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
`ifdef LUT_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_baud  <= (w_tick || r_state == S_IDLE) ? '0 : r_baud + 1'b1;
      r_done  <= r_state == S_STOP && w_tick && r_last;
      if (w_pop) begin
        r_shift <= r_mem[r_rp][7:0];
        r_last  <= r_mem[r_rp][8];
`ifdef LUT_UART_PARITY_EN
        r_par   <= ^r_mem[r_rp][7:0];
`endif
      end else if (r_state == S_DATA && w_tick) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_laplace_lut_uart_tx.sv
// tb_laplace_lut_uart_tx: directed self-checking bench for laplace_lut_uart_tx with CLK_DIV=4
module tb_laplace_lut_uart_tx;
  localparam int CD = 4;
`ifdef LUT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CD;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0, char_last = 1'b0;
  logic       char_ready, tx, busy, done;
  logic [4:0] fifo_level;
  int n_chk = 0, n_fail = 0;

  laplace_lut_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid), .char_last(char_last),
    .char_ready(char_ready), .tx(tx), .busy(busy), .done(done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // expected line level of frame bit b (0 = start) for data d
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (NB == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({tx, busy, char_ready, fifo_level, done} !== {1'b1, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: tx=%b busy=%b ready=%b level=%0d done=%b, need 1 0 1 0 0", tx, busy, char_ready, fifo_level, done);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_chk++;
      if ({tx, busy, char_ready, fifo_level, done} !== {1'b1, 1'b0, 1'b1, 5'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: tx=%b busy=%b ready=%b level=%0d done=%b, need 1 0 1 0 0", c, tx, busy, char_ready, fifo_level, done);
      end
    end
  endtask

  task automatic test_single;
`ifdef LUT_UART_PARITY_EN
    logic [10:0] e = 11'b1_0_01000001_0;
`else
    logic [9:0]  e = 10'b1_01000001_0;
`endif
    char_in = 8'h41; char_valid = 1'b1; char_last = 1'b1;
    @(negedge clk);
    char_valid = 1'b0; char_last = 1'b0;
    n_chk++;
    if (fifo_level !== 5'd1 || tx !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: level=%0d tx=%b busy=%b, need 1 1 1", fifo_level, tx, busy);
    end
    @(negedge clk);
    for (int s = 0; s < FL; s++) begin
      n_chk++;
      if (tx !== e[s/CD] || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_frame cyc %0d: tx=%b done=%b busy=%b, need %b 0 1", s, tx, done, busy, e[s/CD]);
      end
      @(negedge clk);
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: done=%b busy=%b tx=%b, need 1 0 1", done, busy, tx);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_width: done=%b, need 0", done);
    end
  endtask

  task automatic test_backpressure;
    int idx = 0, nd = 0, s;
    logic acc = 1'b0;
    for (int t = 0; t <= 7*FL + 5; t++) begin
      if (acc) idx++;
      s = t - 2;
      if (t == 5) begin
        n_chk++;
        if (fifo_level !== 5'd4 || char_ready !== 1'b0 || idx != 5) begin
          n_fail++;
          $display("FAIL bp_full: level=%0d ready=%b accepted=%0d, need 4 0 5", fifo_level, char_ready, idx);
        end
      end
      if (s >= 0 && s < 7*FL) begin
        n_chk++;
        if (tx !== exp_bit(8'h30 + 8'(s/FL), (s%FL)/CD)) begin
          n_fail++;
          $display("FAIL bp_stream cyc %0d: tx=%b, need %b", s, tx, exp_bit(8'h30 + 8'(s/FL), (s%FL)/CD));
        end
      end
      if (s == 7*FL) begin
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_done: done=%b busy=%b, need 1 0", done, busy);
        end
      end
      if (done === 1'b1) nd++;
      char_valid = idx < 7;
      char_in    = 8'h30 + 8'(idx);
      char_last  = idx == 6;
      acc        = char_valid && char_ready;
      @(negedge clk);
    end
    char_valid = 1'b0; char_last = 1'b0;
    n_chk++;
    if (idx != 7 || nd != 1) begin
      n_fail++;
      $display("FAIL bp_totals: accepted=%0d done_pulses=%0d, need 7 1", idx, nd);
    end
  endtask

  task automatic test_collision;
    logic [7:0] cc [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    int nd = 0, s;
    for (int t = 0; t <= 4*FL + 4; t++) begin
      s = t - 2;
      if (t == FL + 1) begin
        n_chk++;
        if (fifo_level !== 5'd2) begin
          n_fail++;
          $display("FAIL coll_before: level=%0d, need 2", fifo_level);
        end
      end
      if (t == FL + 2) begin
        n_chk++;
        if (fifo_level !== 5'd2 || tx !== 1'b0) begin
          n_fail++;
          $display("FAIL coll_after: level=%0d tx=%b, need 2 0", fifo_level, tx);
        end
      end
      if (s >= 0 && s < 4*FL) begin
        n_chk++;
        if (tx !== exp_bit(cc[s/FL], (s%FL)/CD)) begin
          n_fail++;
          $display("FAIL coll_stream cyc %0d: tx=%b, need %b", s, tx, exp_bit(cc[s/FL], (s%FL)/CD));
        end
      end
      if (s == 4*FL) begin
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL coll_done: done=%b busy=%b, need 1 0", done, busy);
        end
      end
      if (done === 1'b1) nd++;
      char_valid = t <= 2 || t == FL + 1;
      char_in    = t <= 2 ? cc[t] : cc[3];
      char_last  = t == FL + 1;
      @(negedge clk);
    end
    char_valid = 1'b0; char_last = 1'b0;
    n_chk++;
    if (nd != 1) begin
      n_fail++;
      $display("FAIL coll_done_count: done_pulses=%0d, need 1", nd);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pc [3] = '{8'h55, 8'h01, 8'h02};
    int nd = 0;
    for (int t = 0; t <= 19; t++) begin
      char_valid = t <= 2;
      char_in    = t <= 2 ? pc[t] : 8'h00;
      char_last  = 1'b0;
      if (t < 19) @(negedge clk);
    end
    char_valid = 1'b0;
    n_chk++;
    if (tx !== 1'b0 || fifo_level !== 5'd2) begin
      n_fail++;
      $display("FAIL rm_pre: tx=%b level=%0d, need 0 2", tx, fifo_level);
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (tx !== 1'b1 || fifo_level !== 5'd0 || busy !== 1'b0 || char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_async: tx=%b level=%0d busy=%b ready=%b, need 1 0 0 1", tx, fifo_level, busy, char_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
      if (tx !== 1'b1 || fifo_level !== 5'd0) nd += 100;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL rm_quiet: done/line activity code=%0d, need 0", nd);
    end
    char_in = 8'h0D; char_valid = 1'b1; char_last = 1'b1;
    @(negedge clk);
    char_valid = 1'b0; char_last = 1'b0;
    @(negedge clk);
    for (int s = 0; s < FL; s++) begin
      n_chk++;
      if (tx !== exp_bit(8'h0D, s/CD) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rm_frame cyc %0d: tx=%b done=%b, need %b 0", s, tx, done, exp_bit(8'h0D, s/CD));
      end
      @(negedge clk);
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_done: done=%b busy=%b, need 1 0", done, busy);
    end
    @(negedge clk);
  endtask

`ifdef LUT_UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] pd [2] = '{8'h41, 8'h43};
    logic       pp [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      char_in = pd[k]; char_valid = 1'b1; char_last = 1'b1;
      @(negedge clk);
      char_valid = 1'b0; char_last = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 44; s++) begin
        if (s / 4 == 9) begin
          n_chk++;
          if (tx !== pp[k]) begin
            n_fail++;
            $display("FAIL parity_bit %0d cyc %0d: tx=%b, need %b", k, s, tx, pp[k]);
          end
        end
        @(negedge clk);
      end
      n_chk++;
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL parity_len %0d: done=%b after 44 cycles, need 1", k, done);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_collision;
    test_reset_mid;
`ifdef LUT_UART_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/laplace_lut_uart_tx.md
# laplace_lut_uart_tx

Downstream output stage for `tt_um_laplace_lut`: it takes the ASCII characters the LUT emits, one per handshake, buffers them in a small FIFO and serialises them as 8N1 asynchronous serial on one output pin. It marks the end of each message with a `done` pulse and reports its FIFO level, so the top level can throttle the character generator and drive status pins.

## Interface
- `CLK_DIV`, 16: clock cycles per serial bit; legal range 2..255.
- `FIFO_DEPTH`, 4: character FIFO entries; power of two, 2..16.

- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `char_in`  in  8  character from the LUT stage.
- `char_valid`  in  1  `char_in` is valid.
- `char_last`  in  1  qualifies `char_in`: final character of a message.
- `char_ready`  out  1  FIFO can accept a character.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  a frame is on the line, or the FIFO is not empty.
- `done`  out  1  one-cycle pulse when the stop bit of a `char_last` character completes.
- `fifo_level`  out  5  current FIFO occupancy, 0..`FIFO_DEPTH`.

## Operation
- **Push:** occurs when `char_valid && char_ready`. The FIFO stores `{char_last, char_in}`.
  - `char_ready` = (`fifo_level` != `FIFO_DEPTH`), derived from registered state only.
  - When the FIFO is full, `char_valid` is ignored and nothing is dropped or overwritten. The upstream stage holds its data.
- **FSM states:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE with FIFO non-empty → pop the head into the shift register, go to START. `tx`=0.
  - START → after `CLK_DIV` cycles go to DATA.
  - DATA → 8 bits, LSB first, `CLK_DIV` cycles each. A 3-bit bit counter wraps 7→0 on exit.
  - DATA → PARITY if enabled, otherwise STOP.
  - STOP → `tx`=1 for `CLK_DIV` cycles.
  - On leaving STOP: if the FIFO is non-empty, pop and go directly to START with no idle bit. Otherwise go to IDLE.
- **Baud counter:** counts 0..`CLK_DIV`-1. It reloads to 0 on every state change.
- **`done`:** asserted for the single cycle following the last STOP cycle of a frame whose stored last flag = 1.
- **Simultaneous push and pop:** both take effect in the same cycle and `fifo_level` is unchanged. A push in a full cycle is refused even if a pop happens that same cycle.
- **Reset (asynchronous, mid-frame):**
  - Aborts the frame.
  - Empties the FIFO.
  - Returns the FSM to IDLE.

## Timing
- **Reset values:**
  - `tx`=1
  - `busy`=0
  - `done`=0
  - `fifo_level`=0
  - `char_ready`=1
- **Latency:** a character accepted at edge N into an empty FIFO while IDLE appears on `fifo_level`=1 after edge N. The pop occurs at edge N+1, and `tx` goes low after edge N+1, so the start bit begins 1 cycle after acceptance.
- **Frame length:**
  - 10·`CLK_DIV` cycles without parity.
  - 11·`CLK_DIV` cycles with parity.
  - Back-to-back frames are contiguous.
- **`busy`:** high from the cycle after the first accept until the cycle after the final STOP cycle. It falls in the same cycle that `done` rises.
- **`fifo_level`:**
  - increments the cycle after a push.
  - decrements the cycle after a pop.

## Configuration
- **`LUT_UART_PARITY_EN` defined:**
  - An even-parity bit (XOR of the 8 data bits) is sent in the PARITY state between the last data bit and the stop bit, lasting `CLK_DIV` cycles.
  - Frame is 8E1, 11·`CLK_DIV` cycles.
- **`LUT_UART_PARITY_EN` undefined:**
  - No PARITY state exists.
  - Frame is 8N1, 10·`CLK_DIV` cycles.
  - Parity logic is absent from the netlist.

## Test plan
- **Reset values:** `CLK_DIV`=4. Release reset with no input → `tx`=1, `busy`=0, `char_ready`=1, `fifo_level`=0 for 50 cycles.
- **Single character:** push 0x41 with `char_last`=1 → start bit 1 cycle later. Line sequence is 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles (40 cycles total). `done` pulses once the cycle after the stop bit, and `busy` falls with it.
- **Backpressure:** hold `char_valid`=1 with 0x30..0x36, `char_last` on 0x36.
  - After the first pop, 4 more accepts occur, then `char_ready`=0 with `fifo_level`=4.
  - Frames are contiguous with no idle bits between them.
  - Exactly one `done`, after the 0x36 stop bit. All 7 characters are received in order.
- **Push/pop collision:** with the FIFO at level 2, push in the same cycle a frame ends → `fifo_level` stays 2 and the next start bit follows immediately.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 of 0x55 with 2 queued characters → `tx`=1 and `fifo_level`=0 immediately (asynchronous). No `done` occurs. After release, a new push of 0x0D transmits cleanly.
- **Parity:** with `LUT_UART_PARITY_EN`, `CLK_DIV`=4:
  - 0x41 → parity bit 0; frame is 44 cycles.
  - 0x43 → parity bit 1.
